// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word-address fetches, queues in-order responses
// and flushes on redirect. Optional same-cycle bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int               PC_W     = 30,
  parameter int               DATA_W   = 32,
  parameter int               DEPTH    = 4,
  parameter logic [PC_W-1:0]  RESET_PC = {PC_W{1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  output logic [PC_W-1:0]          imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_resp_valid,
  input  logic [DATA_W-1:0]        imem_resp_data,
  output logic [PC_W+DATA_W-1:0]   IF_ID_BUS,
  output logic                     valid,
  input  logic                     next_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + DATA_W;
  localparam logic [CW:0] DEPTH_L  = (CW+1)'(DEPTH);
  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_DRAIN = 1'b1;

  logic [0:0]      r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_resp_pc;
  logic [CW-1:0]   r_out;
  logic [CW-1:0]   r_disc;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [EW-1:0]   r_mem [DEPTH];

  logic [CW:0]     w_occ;
  logic            w_run;
  logic            w_q_nonempty;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_resp_take;
  logic            w_bypass;
  logic            w_valid;
  logic            w_deq;
  logic            w_enq;
  logic [EW-1:0]   w_bus;
  logic [CW-1:0]   w_out_next;
  logic [CW-1:0]   w_out_less_resp;
  logic [CW-1:0]   w_count_next;

  // Queued entries plus in-flight requests reserve slots, so a response always has room.
  assign w_occ        = {1'b0, r_count} + {1'b0, r_out};
  assign w_run        = (r_state == ST_RUN);
  assign w_q_nonempty = (r_count != {CW{1'b0}});
  assign w_req_valid  = !reset && w_run && !redirect_valid && (w_occ < DEPTH_L);
  assign w_req_fire   = w_req_valid && imem_req_ready;
  assign w_resp_take  = !reset && w_run && !redirect_valid && imem_resp_valid;
  assign w_valid      = !reset && !redirect_valid && (w_q_nonempty || w_bypass);
  assign w_deq        = w_valid && next_valid && w_q_nonempty;
  assign w_enq        = w_resp_take && !(w_bypass && next_valid);

  // Head selection; an empty queue presents an all-zero NOP.
  always_comb begin
    w_bypass = 1'b0;
    w_bus    = {EW{1'b0}};
`ifdef FETCH_QUEUE_BYPASS_EN
    w_bypass = w_resp_take && !w_q_nonempty;
`endif
    if (!w_valid) begin
      w_bus = {EW{1'b0}};
    end else if (w_q_nonempty) begin
      w_bus = r_mem[r_rd_ptr];
    end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
      w_bus = {r_resp_pc, imem_resp_data};
`else
      w_bus = {EW{1'b0}};
`endif
    end
  end

  // Outstanding and occupancy next-state arithmetic.
  always_comb begin
    case ({w_req_fire, imem_resp_valid})
      2'b10:   w_out_next = r_out + CW'(1'b1);
      2'b01:   w_out_next = r_out - CW'(1'b1);
      default: w_out_next = r_out;
    endcase
    if (imem_resp_valid) begin
      w_out_less_resp = r_out - CW'(1'b1);
    end else begin
      w_out_less_resp = r_out;
    end
    case ({w_enq, w_deq})
      2'b10:   w_count_next = r_count + CW'(1'b1);
      2'b01:   w_count_next = r_count - CW'(1'b1);
      default: w_count_next = r_count;
    endcase
  end

  // Control state: PCs, counters, pointers and RUN/DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out      <= {CW{1'b0}};
      r_disc     <= {CW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_resp_pc  <= redirect_pc;
      r_count    <= {CW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
      r_out      <= w_out_less_resp;
      r_disc     <= w_out_less_resp;
      r_state    <= (w_out_less_resp != {CW{1'b0}}) ? ST_DRAIN : ST_RUN;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_W'(1'b1);
      if (w_resp_take) r_resp_pc <= r_resp_pc + PC_W'(1'b1);
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1'b1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      r_count <= w_count_next;
      r_out   <= w_out_next;
      case (r_state)
        ST_RUN: r_state <= ST_RUN;
        ST_DRAIN: begin
          // Stale responses are swallowed until every pre-redirect request has returned.
          if (imem_resp_valid) begin
            r_disc <= r_disc - CW'(1'b1);
            if (r_disc <= CW'(1'b1)) r_state <= ST_RUN;
          end else if (r_disc == {CW{1'b0}}) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Queue storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= {r_resp_pc, imem_resp_data};
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign valid          = w_valid;
  assign IF_ID_BUS      = w_bus;
  assign count          = reset ? {CW{1'b0}} : r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences and
// randomized traffic against a queue-based reference model with an in-order memory.
module tb_fetch_queue;

  localparam int PC_W   = 30;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam logic [29:0] DEAD_ADDR = 30'h0000_0BEE;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [29:0] redirect_pc = 30'd0;
  logic        imem_req_valid;
  logic [29:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic [61:0] IF_ID_BUS;
  logic        valid;
  logic        next_valid = 1'b0;
  logic [2:0]  count;

  always #5 clk = ~clk;

  fetch_queue #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(30'd0)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .IF_ID_BUS(IF_ID_BUS), .valid(valid),
    .next_valid(next_valid), .count(count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fdata(input logic [29:0] a);
    if (a == DEAD_ADDR) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A3C, a[15:0]};
  endfunction

  // Memory model: in-order, one response per cycle, latency mem_lat cycles.
  logic [29:0] mem_addr[$];
  longint      mem_due[$];
  longint      cyc = 0;
  longint      last_due = 0;
  int          mem_lat = 1;

  // Reference model state.
  logic [29:0] m_fetch, m_resp;
  int          m_out, m_disc;
  bit          m_drain;
  logic [61:0] m_q[$];

  // Observations of the last stepped cycle.
  bit          obs_req, obs_valid;
  logic [29:0] obs_addr;
  logic [61:0] obs_bus;
  logic [2:0]  obs_cnt;
  logic [29:0] fired[$];
  logic [29:0] taken[$];
  bit          vhist[$];

  task automatic clear_logs();
    fired.delete(); taken.delete(); vhist.delete();
  endtask

  // Called at a posedge; holds reset for two cycles and checks reset outputs.
  task automatic do_reset();
    #1;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 30'd0; next_valid = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    mem_addr.delete(); mem_due.delete(); last_due = cyc;
    m_fetch = 30'd0; m_resp = 30'd0; m_out = 0; m_disc = 0; m_drain = 1'b0; m_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("rst_valid", valid, 64'd0);
      chk("rst_req_valid", imem_req_valid, 64'd0);
      chk("rst_bus", IF_ID_BUS, 64'd0);
      chk("rst_count", count, 64'd0);
      @(posedge clk);
    end
  endtask

  // One clock: drive inputs, check DUT against the model, advance model and memory.
  task automatic step(input bit redir, input logic [29:0] rpc, input bit nv, input bit rdy);
    bit          rv, p_req, p_byp, p_valid;
    logic [31:0] rd;
    logic [61:0] p_bus, ent;
    longint      due;
    int          qs;
    #1;
    rv = 1'b0;
    rd = 32'd0;
    if (mem_due.size() > 0) begin
      if (mem_due[0] == cyc) begin
        rv = 1'b1;
        rd = fdata(mem_addr[0]);
      end
    end
    reset = 1'b0; redirect_valid = redir; redirect_pc = rpc; next_valid = nv;
    imem_req_ready = rdy; imem_resp_valid = rv;
    imem_resp_data = rv ? rd : $urandom;
    @(negedge clk);
    qs      = m_q.size();
    p_req   = !m_drain && !redir && (qs + m_out < DEPTH);
    p_byp   = BYP && !m_drain && !redir && rv && (qs == 0);
    p_valid = !redir && ((qs > 0) || p_byp);
    p_bus   = !p_valid ? 62'd0 : ((qs > 0) ? m_q[0] : {m_resp, rd});
    chk("req_valid", imem_req_valid, p_req);
    chk("req_addr", imem_req_addr, m_fetch);
    chk("valid", valid, p_valid);
    chk("if_id_bus", IF_ID_BUS, p_bus);
    chk("count", count, qs);
    obs_req = imem_req_valid; obs_addr = imem_req_addr; obs_valid = valid;
    obs_bus = IF_ID_BUS; obs_cnt = count;
    if (imem_req_valid && rdy) fired.push_back(imem_req_addr);
    if (valid && nv) taken.push_back(IF_ID_BUS[61:32]);
    vhist.push_back(valid);
    if (rv) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    if (imem_req_valid && rdy) begin
      due = cyc + mem_lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_addr.push_back(imem_req_addr);
      mem_due.push_back(due);
    end
    if (redir) begin
      m_q.delete();
      m_fetch = rpc; m_resp = rpc;
      m_out   = m_out - (rv ? 1 : 0);
      m_disc  = m_out;
      m_drain = (m_disc > 0);
    end else begin
      if (p_req && rdy) begin
        m_fetch = m_fetch + 30'd1;
        m_out++;
      end
      if (rv) m_out--;
      if (m_drain) begin
        if (rv) m_disc--;
        if (m_disc == 0) m_drain = 1'b0;
      end else begin
        if (p_valid && nv && qs > 0) void'(m_q.pop_front());
        if (rv) begin
          ent = {m_resp, rd};
          m_resp = m_resp + 30'd1;
          if (!(p_byp && nv)) m_q.push_back(ent);
        end
      end
    end
    cyc++;
    @(posedge clk);
  endtask

  typedef struct {
    bit          nv;
    bit          exp_req;
    logic [29:0] exp_addr;
    bit          exp_valid;
    logic [29:0] exp_pc;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [61:0] exp_bus;
    logic [29:0] rpc;
    bit          redir, nv, rdy;

    // Back-pressure fill with a single dequeue pulse, 1-cycle memory.
    tbl[0] = '{1'b0, 1'b1, 30'd0, 1'b0, 30'd0, 3'd0};
    tbl[1] = '{1'b0, 1'b1, 30'd1, BYP,  30'd0, 3'd0};
    tbl[2] = '{1'b0, 1'b1, 30'd2, 1'b1, 30'd0, 3'd1};
    tbl[3] = '{1'b0, 1'b1, 30'd3, 1'b1, 30'd0, 3'd2};
    tbl[4] = '{1'b0, 1'b0, 30'd4, 1'b1, 30'd0, 3'd3};
    tbl[5] = '{1'b0, 1'b0, 30'd4, 1'b1, 30'd0, 3'd4};
    tbl[6] = '{1'b1, 1'b0, 30'd4, 1'b1, 30'd0, 3'd4};
    tbl[7] = '{1'b0, 1'b1, 30'd4, 1'b1, 30'd1, 3'd3};
    tbl[8] = '{1'b0, 1'b0, 30'd5, 1'b1, 30'd1, 3'd3};
    tbl[9] = '{1'b0, 1'b0, 30'd5, 1'b1, 30'd1, 3'd4};

    @(posedge clk);

    // Steady-state streaming.
    do_reset(); clear_logs(); mem_lat = 1;
    repeat (12) step(1'b0, 30'd0, 1'b1, 1'b1);
    chk("stream_req_n", fired.size() >= 8, 64'd1);
    for (int i = 0; i < 8 && i < fired.size(); i++) chk("stream_req_addr", fired[i], i);
    chk("stream_out_n", taken.size() >= 6, 64'd1);
    for (int i = 0; i < 6 && i < taken.size(); i++) chk("stream_out_pc", taken[i], i);
    for (int i = 2; i < vhist.size(); i++) chk("stream_steady_valid", vhist[i], 64'd1);

    // Table-driven fill/drain vectors.
    do_reset(); mem_lat = 1;
    for (int r = 0; r < 10; r++) begin
      step(1'b0, 30'd0, tbl[r].nv, 1'b1);
      exp_bus = tbl[r].exp_valid ? {tbl[r].exp_pc, fdata(tbl[r].exp_pc)} : 62'd0;
      chk("tbl_req_valid", obs_req, tbl[r].exp_req);
      chk("tbl_req_addr", obs_addr, tbl[r].exp_addr);
      chk("tbl_valid", obs_valid, tbl[r].exp_valid);
      chk("tbl_bus", obs_bus, exp_bus);
      chk("tbl_count", obs_cnt, tbl[r].exp_cnt);
    end

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset(); clear_logs(); mem_lat = 3;
    step(1'b0, 30'd0, 1'b1, 1'b1);
    step(1'b0, 30'd0, 1'b1, 1'b1);
    step(1'b1, 30'h100, 1'b1, 1'b1);
    chk("redir_cycle_req", obs_req, 64'd0);
    chk("redir_cycle_valid", obs_valid, 64'd0);
    repeat (2) begin
      step(1'b0, 30'd0, 1'b1, 1'b1);
      chk("drain_req", obs_req, 64'd0);
      chk("drain_valid", obs_valid, 64'd0);
    end
    step(1'b0, 30'd0, 1'b1, 1'b1);
    chk("post_drain_req", obs_req, 64'd1);
    chk("post_drain_addr", obs_addr, 64'h100);
    for (int i = 0; i < 10 && taken.size() == 0; i++) step(1'b0, 30'd0, 1'b1, 1'b1);
    chk("redir_out_seen", taken.size() > 0, 64'd1);
    if (taken.size() > 0) chk("redir_first_pc", taken[0], 64'h100);

    // Redirect colliding with a response and a dequeue.
    do_reset(); mem_lat = 1;
    repeat (3) step(1'b0, 30'd0, 1'b0, 1'b1);
    step(1'b1, 30'h40, 1'b1, 1'b1);
    chk("collide_valid", obs_valid, 64'd0);
    chk("collide_req", obs_req, 64'd0);
    step(1'b0, 30'd0, 1'b1, 1'b1);
    chk("collide_next_count", obs_cnt, 64'd0);
    chk("collide_next_valid", obs_valid, 64'd0);
    chk("collide_next_addr", obs_addr, 64'h40);

    // Fetch PC wrap-around.
    do_reset(); clear_logs(); mem_lat = 1;
    step(1'b1, 30'h3FFF_FFFF, 1'b1, 1'b1);
    repeat (6) step(1'b0, 30'd0, 1'b1, 1'b1);
    chk("wrap_req_n", fired.size() >= 2, 64'd1);
    if (fired.size() >= 2) begin
      chk("wrap_req_addr0", fired[0], 64'h3FFF_FFFF);
      chk("wrap_req_addr1", fired[1], 64'd0);
    end
    chk("wrap_out_n", taken.size() >= 2, 64'd1);
    if (taken.size() >= 2) begin
      chk("wrap_out_pc0", taken[0], 64'h3FFF_FFFF);
      chk("wrap_out_pc1", taken[1], 64'd0);
    end

    // Response into an empty queue: same-cycle with bypass, next cycle without.
    do_reset(); mem_lat = 1;
    step(1'b1, DEAD_ADDR, 1'b1, 1'b1);
    step(1'b0, 30'd0, 1'b1, 1'b1);
    step(1'b0, 30'd0, 1'b1, 1'b1);
    chk("empty_resp_valid", obs_valid, BYP);
    chk("empty_resp_bus", obs_bus, BYP ? {DEAD_ADDR, 32'hDEAD_BEEF} : 62'd0);
    chk("empty_resp_count", obs_cnt, 64'd0);
    step(1'b0, 30'd0, 1'b1, 1'b1);
    chk("empty_next_valid", obs_valid, 64'd1);
    chk("empty_next_bus", obs_bus,
        BYP ? {DEAD_ADDR + 30'd1, fdata(DEAD_ADDR + 30'd1)} : {DEAD_ADDR, 32'hDEAD_BEEF});
    chk("empty_next_count", obs_cnt, BYP ? 64'd0 : 64'd1);

    // Randomized traffic against the model.
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      mem_lat = 1 + blk;
      for (int i = 0; i < 1500; i++) begin
        if (i % 200 == 199) mem_lat = $urandom_range(1, 4);
        redir = ($urandom_range(0, 19) == 0);
        rpc   = ($urandom_range(0, 3) == 0) ? (30'h3FFF_FFFC + 30'($urandom_range(0, 3)))
                                            : 30'($urandom);
        nv    = ($urandom_range(0, 3) != 0);
        rdy   = ($urandom_range(0, 4) != 0);
        step(redir, rpc, nv, rdy);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
